// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and the default datapath width.
package mips_pkg;

  localparam int unsigned MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MFX   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared engine: add-shift for multiply,
// restoring subtract-shift for divide (one quotient bit per call).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_opnd,
  input  logic            i_div,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sel;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    w_sum  = {1'b0, i_acc} + {1'b0, i_opnd};
    w_sel  = i_q[0] ? w_sum : {1'b0, i_acc};
    // Divide: the shifted partial remainder can briefly need XLEN+1 bits.
    w_sh   = {i_acc, i_q[XLEN-1]};
    w_ge   = (w_sh >= {1'b0, i_opnd});
    w_diff = w_sh - {1'b0, i_opnd};
    o_acc  = '0;
    o_q    = '0;
    if (i_div) begin
      o_acc = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
      o_q   = {i_q[XLEN-2:0], w_ge};
    end else begin
      o_acc = w_sel[XLEN:1];
      o_q   = {w_sel[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: IDLE -> RUN (STEPS
// iterations on magnitudes) -> FIX (sign correction, HI/LO write) -> IDLE.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned XLEN  = mips_pkg::MD_XLEN,
  parameter int unsigned STEPS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            cancel,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]     LAST = CW'(STEPS - 1);
  localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
  localparam logic [2*XLEN-1:0] PONE = (2*XLEN)'(1);

  md_state_e       r_state;
  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_opnd;
  logic            r_div;
  logic            r_neg_p;
  logic            r_neg_r;
  logic            r_dz;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  md_op_e            w_op;
  logic              w_accept;
  logic              w_is_md;
  logic              w_is_div;
  logic              w_signed;
  logic [XLEN-1:0]   w_rs_mag;
  logic [XLEN-1:0]   w_rt_mag;
  logic [XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]   w_q_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  always_comb begin
    w_op     = md_op_e'(op);
    w_accept = op_valid && !r_busy && !cancel;
    w_is_md  = (w_op == MD_MULT) || (w_op == MD_MULTU) ||
               (w_op == MD_DIV)  || (w_op == MD_DIVU);
    w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
    w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    w_rs_mag = (w_signed && rs[XLEN-1]) ? (~rs + ONE) : rs;
    w_rt_mag = (w_signed && rt[XLEN-1]) ? (~rt + ONE) : rt;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_opnd (r_opnd),
    .i_div  (r_div),
    .o_acc  (w_acc_nxt),
    .o_q    (w_q_nxt)
  );

  // Sign fix applied in FIX; a zero divisor forces an all-ones quotient.
  always_comb begin
    w_prod = r_neg_p ? (~{r_acc, r_q} + PONE) : {r_acc, r_q};
    w_quo  = r_dz ? '1 : (r_neg_p ? (~r_q + ONE) : r_q);
    w_rem  = r_neg_r ? (~r_acc + ONE) : r_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_p <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_md) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_q     <= w_rs_mag;
              r_opnd  <= w_rt_mag;
              r_div   <= w_is_div;
              r_neg_p <= w_signed && (rs[XLEN-1] ^ rt[XLEN-1]);
              r_neg_r <= w_signed && rs[XLEN-1];
              r_dz    <= w_is_div && (rt == '0);
            end else if (w_op == MD_MTHI) begin
              r_hi <= rs;
            end else if (w_op == MD_MTLO) begin
              r_lo <= rs;
            end
          end
        end
        ST_RUN: begin
          if (cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*XLEN-1:XLEN];
              r_lo <= w_prod[XLEN-1:0];
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign stall = op_valid && r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops
// checked against an arithmetic model of the HI/LO architectural state.
module tb_muldiv_ctrl;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, MFX = 3'd7;

  logic        clk = 1'b0;
  logic        rst, op_valid, cancel;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(32), .STEPS(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted op, from plain integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MULTU: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      DIV: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      DIVU: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  // Presents one op for a single edge, then counts cycles with busy high.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    tick();
    op_valid = 1'b0; op = NOP;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op = NOP; rs = '0; rt = '0; cancel = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    op_valid = 1'b1; op = MULT; rs = 32'd7; rt = 32'd6;
    tick();
    op_valid = 1'b0; op = NOP;
    repeat (9) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", lo); end
    m_hi = '0; m_lo = '0;
    issue(MULTU, 32'd7, 32'd6, cyc);
    model(MULTU, 32'd7, 32'd6);
    total++; if (cyc != 33) begin bad++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL multu_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL multu_lo got=%h exp=42", lo); end
  endtask

  task automatic test_directed();
    logic [2:0]  vo[6];
    logic [31:0] va[6], vb[6], vh[6], vl[6];
    int cyc;
    vo[0] = MULT;  va[0] = 32'hFFFF_FFFF; vb[0] = 32'h2;         vh[0] = 32'hFFFF_FFFF; vl[0] = 32'hFFFF_FFFE;
    vo[1] = MULTU; va[1] = 32'hFFFF_FFFF; vb[1] = 32'h2;         vh[1] = 32'h1;         vl[1] = 32'hFFFF_FFFE;
    vo[2] = DIV;   va[2] = 32'hFFFF_FFF9; vb[2] = 32'h2;         vh[2] = 32'hFFFF_FFFF; vl[2] = 32'hFFFF_FFFD;
    vo[3] = DIVU;  va[3] = 32'd100;       vb[3] = 32'd7;         vh[3] = 32'd2;         vl[3] = 32'd14;
    vo[4] = DIV;   va[4] = 32'h8000_0000; vb[4] = 32'hFFFF_FFFF; vh[4] = 32'h0;         vl[4] = 32'h8000_0000;
    vo[5] = DIVU;  va[5] = 32'h1234;      vb[5] = 32'h0;         vh[5] = 32'h1234;      vl[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      issue(vo[i], va[i], vb[i], cyc);
      model(vo[i], va[i], vb[i]);
      total++; if (cyc != 33) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=33", i, cyc); end
      total++; if (hi !== vh[i]) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, vh[i]); end
      total++; if (lo !== vl[i]) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, vl[i]); end
    end
  endtask

  task automatic test_stall();
    int n, stall_err, cyc;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    op_valid = 1'b1; op = MULT; rs = a1; rt = b1;
    tick();
    model(MULT, a1, b1);
    op = MFX;
    stall_err = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (stall !== 1'b1) stall_err++;
      tick();
    end
    op = MULT; rs = a2; rt = b2;
    n = 0;
    #1;
    while (busy === 1'b1 && n < 100) begin
      if (stall !== 1'b1) stall_err++;
      tick();
      #1;
      n++;
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_while_busy errors=%0d exp=0", stall_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy_fall got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_released got=%b exp=0", stall); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL stall_first_result got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
    tick();
    op_valid = 1'b0; op = NOP;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_second_accept got=%b exp=1", busy); end
    model(MULT, a2, b2);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL stall_second_result got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_mtlo();
    op_valid = 1'b1; op = MTLO; rs = 32'hA5A5_A5A5;
    tick();
    op_valid = 1'b0; op = NOP;
    model(MTLO, 32'hA5A5_A5A5, 32'd0);
    total++; if (lo !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mtlo_lo got=%h exp=a5a5a5a5", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    total++; if (hi !== m_hi) begin bad++; $display("FAIL mtlo_hi got=%h exp=%h", hi, m_hi); end
  endtask

  task automatic test_cancel();
    int cyc;
    issue(MTHI, 32'h11, 32'd0, cyc);
    issue(MTLO, 32'h22, 32'd0, cyc);
    m_hi = 32'h11; m_lo = 32'h22;
    op_valid = 1'b1; op = MULT; rs = $urandom; rt = $urandom | 32'h1;
    tick();
    op_valid = 1'b0; op = NOP;
    repeat (5) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cancel_pre_busy got=%b exp=1", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'h11) begin bad++; $display("FAIL cancel_hi got=%h exp=11", hi); end
    total++; if (lo !== 32'h22) begin bad++; $display("FAIL cancel_lo got=%h exp=22", lo); end
    cancel = 1'b1; op_valid = 1'b1; op = MTHI; rs = 32'hDEAD_BEEF;
    tick();
    op = MULT; rs = 32'd3; rt = 32'd5;
    tick();
    cancel = 1'b0; op_valid = 1'b0; op = NOP;
    total++; if (hi !== 32'h11) begin bad++; $display("FAIL cancel_idle_mthi got=%h exp=11", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_idle_mult got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int cyc;
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      issue(o, a, b, cyc);
      model(o, a, b);
      total++;
      if (cyc != (((o >= MULT) && (o <= DIVU)) ? 33 : 0)) begin
        bad++; $display("FAIL rand%0d_latency op=%0d got=%0d", i, o, cyc);
      end
      total++;
      if (hi !== m_hi || lo !== m_lo) begin
        bad++; $display("FAIL rand%0d_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_directed();
    test_stall();
    test_mtlo();
    test_cancel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
